// File: rtl/qcore_div_unit.sv
// rtl/qcore_div_unit.sv - iterative restoring divider for the core register bank
//
// Computes one quotient bit per clock. Quotient and remainder are held on
// quo_o / rem_o (special registers 4 and 5) and change only when an operation
// completes, so the register bank may read them at any time.
//
// Optional feature macro: QICK_DIV_SIGNED_EN
//   defined   : sign_i selects two's-complement signed division
//   undefined : sign_i is ignored, all operations are unsigned
//
// Ports:
//   clk_i    in      core clock
//   rst_ni   in      asynchronous active-low reset
//   halt_i   in      freezes all state while high
//   clear_i  in      synchronous abort-and-zero (beats halt_i and start_i)
//   start_i  in      start strobe, accepted when ready_o=1 and halt_i=0
//   sign_i   in      signed operation request
//   A_i      in  DW  dividend
//   B_i      in  DW  divisor
//   ready_o  out     idle, results valid
//   div0_o   out     last completed operation had divisor 0
//   quo_o    out DW  quotient
//   rem_o    out DW  remainder

module qcore_div_unit #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          halt_i,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic          sign_i,
  input  logic [DW-1:0] A_i,
  input  logic [DW-1:0] B_i,
  output logic          ready_o,
  output logic          div0_o,
  output logic [DW-1:0] quo_o,
  output logic [DW-1:0] rem_o
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q_r;     // dividend shifting out, quotient shifting in
  logic [DW-1:0] r_r;     // partial remainder
  logic [DW-1:0] div_r;   // divisor magnitude
  logic [DW-1:0] a_r;     // original dividend, returned as remainder on divide by zero

  // Operand magnitudes and result sign handling
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;
  logic          start_neg_q;
  logic          start_neg_r;
  logic [DW-1:0] quo_fix;
  logic [DW-1:0] rem_fix;

`ifdef QICK_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic a_neg;
  logic b_neg;

  assign a_neg       = sign_i & A_i[DW-1];
  assign b_neg       = sign_i & B_i[DW-1];
  // -2^(DW-1) maps onto itself, which is its correct unsigned magnitude
  assign a_mag       = a_neg ? (-A_i) : A_i;
  assign b_mag       = b_neg ? (-B_i) : B_i;
  assign start_neg_q = a_neg ^ b_neg;
  assign start_neg_r = a_neg;
  assign quo_fix     = neg_q ? (-q_r) : q_r;
  assign rem_fix     = neg_r ? (-r_r) : r_r;
`else
  logic unused_sign;

  assign unused_sign = sign_i;
  assign a_mag       = A_i;
  assign b_mag       = B_i;
  assign start_neg_q = 1'b0;
  assign start_neg_r = 1'b0;
  assign quo_fix     = q_r;
  assign rem_fix     = r_r;
`endif

  // One restoring step. The shifted remainder is DW+1 bits so the compare and
  // subtract cannot overflow. The borrow out of the subtraction is the
  // "remainder < divisor" decision; it is only exact while r_r < div_r, which
  // holds for every nonzero divisor. Divide by zero results are forced in DONE.
  logic [DW:0]   r_shift;
  logic [DW:0]   r_diff;
  logic          take;
  logic [DW-1:0] r_next;

  assign r_shift = {r_r, q_r[DW-1]};
  assign r_diff  = r_shift - {1'b0, div_r};
  assign take    = ~r_diff[DW];
  assign r_next  = take ? r_diff[DW-1:0] : r_shift[DW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      div_r   <= '0;
      a_r     <= '0;
      ready_o <= 1'b1;
      div0_o  <= 1'b0;
      quo_o   <= '0;
      rem_o   <= '0;
`ifdef QICK_DIV_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else if (clear_i) begin
      state   <= IDLE;
      cnt     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      div_r   <= '0;
      a_r     <= '0;
      ready_o <= 1'b1;
      div0_o  <= 1'b0;
      quo_o   <= '0;
      rem_o   <= '0;
`ifdef QICK_DIV_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else if (!halt_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            q_r     <= a_mag;
            div_r   <= b_mag;
            a_r     <= A_i;
            r_r     <= '0;
            cnt     <= CW'(DW - 1);
            ready_o <= 1'b0;
            state   <= CALC;
`ifdef QICK_DIV_SIGNED_EN
            neg_q   <= start_neg_q;
            neg_r   <= start_neg_r;
`endif
          end
        end

        CALC: begin
          r_r <= r_next;
          q_r <= {q_r[DW-2:0], take};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= DONE;
          end
        end

        DONE: begin
          if (div_r == '0) begin
            quo_o  <= '1;
            rem_o  <= a_r;
            div0_o <= 1'b1;
          end else begin
            quo_o  <= quo_fix;
            rem_o  <= rem_fix;
            div0_o <= 1'b0;
          end
          ready_o <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qcore_div_unit.sv
// tb/tb_qcore_div_unit.sv - directed self-checking bench for qcore_div_unit (DW=32 and DW=8)

module tb_qcore_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        h32, c32, s32, sg32;
  logic [31:0] a32, b32;
  logic        rdy32, z32;
  logic [31:0] q32, m32;

  logic        h8, c8, s8, sg8;
  logic [7:0]  a8, b8;
  logic        rdy8, z8;
  logic [7:0]  q8, m8;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  qcore_div_unit #(.DW(32)) u_dut32 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .halt_i  (h32),
    .clear_i (c32),
    .start_i (s32),
    .sign_i  (sg32),
    .A_i     (a32),
    .B_i     (b32),
    .ready_o (rdy32),
    .div0_o  (z32),
    .quo_o   (q32),
    .rem_o   (m32)
  );

  qcore_div_unit #(.DW(8)) u_dut8 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .halt_i  (h8),
    .clear_i (c8),
    .start_i (s8),
    .sign_i  (sg8),
    .A_i     (a8),
    .B_i     (b8),
    .ready_o (rdy8),
    .div0_o  (z8),
    .quo_o   (q8),
    .rem_o   (m8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; call away from the rising edge.
  task automatic start_32(input logic [31:0] a, input logic [31:0] b, input logic sg);
    a32 = a; b32 = b; sg32 = sg; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
  endtask

  // Counts falling edges with ready low; returns at the first falling edge with ready high.
  task automatic wait_32(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy32) break;
      n++;
    end
  endtask

  task automatic div_32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int n;
    start_32(a, b, sg);
    wait_32(n);
    check({tag, "_lat"}, n, 33);
    check({tag, "_quo"}, q32, eq);
    check({tag, "_rem"}, m32, er);
    check({tag, "_div0"}, {31'd0, z32}, {31'd0, ez});
  endtask

  task automatic div_8(input string tag, input logic [7:0] a, input logic [7:0] b);
    int n;
    logic [7:0] eq, er;
    eq = (b == 8'd0) ? 8'hFF : a / b;
    er = (b == 8'd0) ? a : a % b;
    a8 = a; b8 = b; sg8 = 1'b0; s8 = 1'b1;
    @(posedge clk);
    #1 s8 = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy8) break;
      n++;
    end
    check({tag, "_lat"}, n, 9);
    check({tag, "_quo"}, {24'd0, q8}, {24'd0, eq});
    check({tag, "_rem"}, {24'd0, m8}, {24'd0, er});
    check({tag, "_div0"}, {31'd0, z8}, {31'd0, (b == 8'd0)});
  endtask

  initial begin
    int n, m;
    rst_n = 1'b0;
    h32 = 0; c32 = 0; s32 = 0; sg32 = 0; a32 = '0; b32 = '0;
    h8 = 0; c8 = 0; s8 = 0; sg8 = 0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_ready", {31'd0, rdy32}, 32'd1);
    check("rst_div0", {31'd0, z32}, 32'd0);
    check("rst_quo", q32, 32'd0);
    check("rst_rem", m32, 32'd0);

    // Basic unsigned, divide by zero, recovery from divide by zero
    div_32("d100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    div_32("d5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    div_32("d9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    // Halt for 5 cycles mid-calculation
    start_32(32'd1000, 32'd10, 1'b0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n++;
    end
    h32 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n++;
    end
    check("halt_hold_quo", q32, 32'd3);
    check("halt_hold_ready", {31'd0, rdy32}, 32'd0);
    h32 = 1'b0;
    wait_32(m);
    check("halt_lat", n + m, 38);
    check("halt_quo", q32, 32'd100);
    check("halt_rem", m32, 32'd0);

    // Start while busy is ignored; outputs held during calculation
    start_32(32'd50, 32'd5, 1'b0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    check("busy_hold_quo", q32, 32'd100);
    a32 = 32'd7; b32 = 32'd1; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    wait_32(m);
    check("busy_lat", n + m, 33);
    check("busy_quo", q32, 32'd10);
    check("busy_rem", m32, 32'd0);

    // Clear mid-calculation
    start_32(32'd77, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    c32 = 1'b1;
    @(posedge clk);
    #1 c32 = 1'b0;
    check("clr_ready", {31'd0, rdy32}, 32'd1);
    check("clr_quo", q32, 32'd0);
    check("clr_rem", m32, 32'd0);
    check("clr_div0", {31'd0, z32}, 32'd0);
    div_32("after_clr", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0);

    // Start coinciding with clear, then with halt: both dropped
    a32 = 32'd1; b32 = 32'd1; s32 = 1'b1; c32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0; c32 = 1'b0;
    @(negedge clk);
    check("start_clr_ready", {31'd0, rdy32}, 32'd1);
    check("start_clr_quo", q32, 32'd0);
    s32 = 1'b1; h32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0; h32 = 1'b0;
    @(negedge clk);
    check("start_halt_ready", {31'd0, rdy32}, 32'd1);
    @(negedge clk);
    check("start_halt_ready2", {31'd0, rdy32}, 32'd1);

    // Back-to-back: second start issued in the first ready cycle
    div_32("b2b_a", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);
    div_32("b2b_b", 32'd12345, 32'd1000, 1'b0, 32'd12, 32'd345, 1'b0);

`ifdef QICK_DIV_SIGNED_EN
    div_32("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    div_32("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    div_32("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    div_32("s_unsigned", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
`else
    div_32("u_sign_ign", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    // Asynchronous reset during calculation
    start_32(32'd1, 32'd1, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, rdy32}, 32'd1);
    check("arst_quo", q32, 32'd0);
    check("arst_rem", m32, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // DW=8 sweep
    div_8("w8_255_1", 8'd255, 8'd1);
    div_8("w8_200_0", 8'd200, 8'd0);
    div_8("w8_7_200", 8'd7, 8'd200);
    div_8("w8_128_3", 8'd128, 8'd3);
    for (int i = 0; i < 12; i++) begin
      div_8("w8_rnd", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
